// File: rtl/dcache_pkg.sv
// Shared load-size encodings and block geometry helpers for the DCache load path.
package dcache_pkg;

    localparam logic [1:0] LS_BYTE = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_WORD = 2'b10;

    typedef enum logic [1:0] {
        BufEmpty,
        BufOne,
        BufFull
    } buf_state_e;

    function automatic int unsigned block_width(input int unsigned offset_len);
        return 8 << offset_len;
    endfunction

    function automatic int unsigned word_count(input int unsigned offset_len);
        return 1 << (offset_len - 2);
    endfunction

endpackage

// File: rtl/dcache_load_extract_load_extend.sv
// Combinational word/byte/half select with sign/zero extension and misalignment detect.
// Misalignment trapping is enabled by defining DCACHE_LDX_MISALIGN_TRAP_EN.
module load_extend
    import dcache_pkg::*;
#(
    parameter int unsigned Offset_len = 6
) (
    input  logic [block_width(Offset_len)-1:0] block_i,
    input  logic [Offset_len-1:0]              offset_i,
    input  logic [1:0]                         size_i,
    input  logic                               unsigned_i,
    output logic [31:0]                        data_o,
    output logic                               err_o
);

    localparam int unsigned BlockW = block_width(Offset_len);

    logic [31:0] word;
    logic [31:0] byte_sh;
    logic [31:0] half_sh;

    if (Offset_len > 2) begin : g_multi_word
        logic [BlockW-1:0] block_sh;
        assign block_sh = block_i >> {offset_i[Offset_len-1:2], 5'b00000};
        assign word     = block_sh[31:0];
    end else begin : g_single_word
        assign word = block_i[31:0];
    end

    assign byte_sh = word >> {offset_i[1:0], 3'b000};
    assign half_sh = word >> {offset_i[1], 4'b0000};

    always_comb begin
        data_o = word;
        err_o  = 1'b0;
        case (size_i)
            LS_BYTE: data_o = {{24{~unsigned_i & byte_sh[7]}}, byte_sh[7:0]};
            LS_HALF: data_o = {{16{~unsigned_i & half_sh[15]}}, half_sh[15:0]};
            default: data_o = word;
        endcase
`ifdef DCACHE_LDX_MISALIGN_TRAP_EN
        case (size_i)
            LS_BYTE: err_o = 1'b0;
            LS_HALF: err_o = offset_i[0];
            LS_WORD: err_o = |offset_i[1:0];
            default: err_o = 1'b1;
        endcase
        if (err_o) begin
            data_o = 32'h0;
        end
`endif
    end

endmodule

// File: rtl/dcache_load_extract.sv
// DCache load-return stage: extracts the addressed datum and registers it in a 2-entry skid buffer.
// Optional misalignment trap: DCACHE_LDX_MISALIGN_TRAP_EN (see load_extend).
module dcache_load_extract
    import dcache_pkg::*;
#(
    parameter int unsigned Offset_len = 6,
    parameter int unsigned ID_len     = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [block_width(Offset_len)-1:0] in_block,
    input  logic [Offset_len-1:0]              in_offset,
    input  logic [1:0]                         in_size,
    input  logic                               in_unsigned,
    input  logic [ID_len-1:0]                  in_id,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [31:0]                        out_data,
    output logic [ID_len-1:0]                  out_id,
    output logic                               out_err
);

    logic [31:0] ext_data;
    logic        ext_err;

    load_extend #(
        .Offset_len(Offset_len)
    ) u_load_extend (
        .block_i   (in_block),
        .offset_i  (in_offset),
        .size_i    (in_size),
        .unsigned_i(in_unsigned),
        .data_o    (ext_data),
        .err_o     (ext_err)
    );

    buf_state_e        state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [31:0]       head_data_q, head_data_d;
    logic [ID_len-1:0] head_id_q, head_id_d;
    logic              head_err_q, head_err_d;
    logic [31:0]       skid_data_q, skid_data_d;
    logic [ID_len-1:0] skid_id_q, skid_id_d;
    logic              skid_err_q, skid_err_d;
    logic              in_fire;
    logic              out_fire;

    assign out_valid = (state_q != BufEmpty);
    assign in_ready  = in_ready_q;
    assign out_data  = head_data_q;
    assign out_id    = head_id_q;
    assign out_err   = head_err_q;
    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_id_d   = head_id_q;
        head_err_d  = head_err_q;
        skid_data_d = skid_data_q;
        skid_id_d   = skid_id_q;
        skid_err_d  = skid_err_q;
        case (state_q)
            BufEmpty: begin
                if (in_fire) begin
                    head_data_d = ext_data;
                    head_id_d   = in_id;
                    head_err_d  = ext_err;
                    state_d     = BufOne;
                end
            end
            BufOne: begin
                if (in_fire && out_fire) begin
                    head_data_d = ext_data;
                    head_id_d   = in_id;
                    head_err_d  = ext_err;
                end else if (in_fire) begin
                    skid_data_d = ext_data;
                    skid_id_d   = in_id;
                    skid_err_d  = ext_err;
                    state_d     = BufFull;
                end else if (out_fire) begin
                    state_d = BufEmpty;
                end
            end
            BufFull: begin
                if (out_fire) begin
                    head_data_d = skid_data_q;
                    head_id_d   = skid_id_q;
                    head_err_d  = skid_err_q;
                    state_d     = BufOne;
                end
            end
            default: state_d = BufEmpty;
        endcase
        // Registered so in_ready never combinationally depends on out_ready.
        in_ready_d = (state_d != BufFull);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= BufEmpty;
            in_ready_q  <= 1'b1;
            head_data_q <= '0;
            head_id_q   <= '0;
            head_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_id_q   <= '0;
            skid_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            head_data_q <= head_data_d;
            head_id_q   <= head_id_d;
            head_err_q  <= head_err_d;
            skid_data_q <= skid_data_d;
            skid_id_q   <= skid_id_d;
            skid_err_q  <= skid_err_d;
        end
    end

endmodule

// File: tb/tb_dcache_load_extract.sv
// Self-checking bench for dcache_load_extract: directed scenarios plus randomized traffic vs a queue model.
module tb_dcache_load_extract;

    localparam int OFF = 6;
    localparam int IDW = 4;
    localparam int BW  = 8 << OFF;
    localparam int NW  = BW / 32;

    typedef struct packed {
        logic [31:0]    data;
        logic [IDW-1:0] id;
        logic           err;
    } ent_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [BW-1:0]  in_block;
    logic [OFF-1:0] in_offset;
    logic [1:0]     in_size;
    logic           in_unsigned;
    logic [IDW-1:0] in_id;
    logic           out_valid;
    logic           out_ready;
    logic [31:0]    out_data;
    logic [IDW-1:0] out_id;
    logic           out_err;

    int n_checks = 0;
    int n_errors = 0;

    ent_t           q[$];
    ent_t           last;
    logic [IDW-1:0] emitted[$];

    dcache_load_extract #(
        .Offset_len(OFF),
        .ID_len    (IDW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_block   (in_block),
        .in_offset  (in_offset),
        .in_size    (in_size),
        .in_unsigned(in_unsigned),
        .in_id      (in_id),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_id     (out_id),
        .out_err    (out_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] byte_at(input logic [BW-1:0] blk, input int a);
        logic [BW-1:0] t;
        t = blk >> (8 * a);
        return t[7:0];
    endfunction

    // Reference: treat the block as a little-endian byte array addressed by offset.
    function automatic ent_t model(input logic [BW-1:0] blk, input int off, input int sz,
                                   input bit uns, input logic [IDW-1:0] id);
        ent_t  e;
        int    a;
        bit    bad;
        logic [31:0] v;
        v = 0;
        if (sz == 0) begin
            v = 32'(byte_at(blk, off));
            if (!uns && v[7]) v = v + 32'hFFFF_FF00;
        end else if (sz == 1) begin
            a = off - (off % 2);
            v = 32'(byte_at(blk, a)) + 32'(byte_at(blk, a + 1)) * 256;
            if (!uns && v[15]) v = v + 32'hFFFF_0000;
        end else begin
            a = off - (off % 4);
            for (int k = 0; k < 4; k++) v = v + (32'(byte_at(blk, a + k)) << (8 * k));
        end
        bad = (sz == 1 && (off % 2) != 0) || (sz == 2 && (off % 4) != 0) || sz == 3;
        e.id = id;
`ifdef DCACHE_LDX_MISALIGN_TRAP_EN
        e.err  = bad;
        e.data = bad ? 32'h0 : v;
`else
        e.err  = 1'b0;
        e.data = v;
        if (bad) e.err = 1'b0;
`endif
        return e;
    endfunction

    task automatic check_outputs();
        check_eq("in_ready", 32'(in_ready), 32'(q.size() < 2));
        check_eq("out_valid", 32'(out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            check_eq("out_data", out_data, q[0].data);
            check_eq("out_id", 32'(out_id), 32'(q[0].id));
            check_eq("out_err", 32'(out_err), 32'(q[0].err));
        end else begin
            check_eq("idle_data", out_data, last.data);
            check_eq("idle_id", 32'(out_id), 32'(last.id));
            check_eq("idle_err", 32'(out_err), 32'(last.err));
        end
    endtask

    // One clock: update the model with the values the DUT samples, then check at negedge.
    task automatic step();
        bit   in_fire;
        bit   out_fire;
        ent_t e;
        @(posedge clk);
        if (rst) begin
            q.delete();
            last = '0;
        end else begin
            in_fire  = in_valid && (q.size() < 2);
            out_fire = (q.size() > 0) && out_ready;
            if (out_fire) begin
                last = q.pop_front();
                emitted.push_back(last.id);
            end
            if (in_fire) begin
                e = model(in_block, int'(in_offset), int'(in_size), in_unsigned, in_id);
                q.push_back(e);
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < NW; i++) in_block[32*i +: 32] = 32'h1000_0000 + 32'(i);
    endtask

    task automatic set_req(input int off, input int sz, input bit uns, input int id);
        in_offset   = OFF'(off);
        in_size     = 2'(sz);
        in_unsigned = uns;
        in_id       = IDW'(id);
    endtask

    // Issue a single request with out_ready=1; result is checked one cycle after transfer.
    task automatic single(input string tag, input int off, input int sz, input bit uns,
                          input int id, input logic [31:0] exp_data, input bit exp_err);
        out_ready = 1'b1;
        set_req(off, sz, uns, id);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_data"}, out_data, exp_data);
        check_eq({tag, "_id"}, 32'(out_id), 32'(id));
        check_eq({tag, "_err"}, 32'(out_err), 32'(exp_err));
        step();
    endtask

    initial begin
        int n0;
        last        = '0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        in_block    = '0;
        set_req(0, 0, 1'b0, 0);
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_data", out_data, 32'd0);
        check_eq("rst_out_id", 32'(out_id), 32'd0);
        check_eq("rst_out_err", 32'(out_err), 32'd0);

        // Directed extraction cases
        fill_ramp();
        single("word3c", 'h3C, 2, 1'b0, 5, 32'h1000_000F, 1'b0);
        in_block[32*2 +: 32] = 32'h8081_F2F3;
        single("sbyte", 'h09, 0, 1'b0, 6, 32'hFFFF_FFF2, 1'b0);
        single("ubyte", 'h09, 0, 1'b1, 7, 32'h0000_00F2, 1'b0);
        single("shalf", 'h0A, 1, 1'b0, 8, 32'hFFFF_8081, 1'b0);
        single("uhalf", 'h0A, 1, 1'b1, 9, 32'h0000_8081, 1'b0);
`ifdef DCACHE_LDX_MISALIGN_TRAP_EN
        single("misw", 'h05, 2, 1'b0, 10, 32'h0, 1'b1);
        single("rsvd", 'h04, 3, 1'b0, 11, 32'h0, 1'b1);
`else
        single("misw", 'h05, 2, 1'b0, 10, 32'h1000_0001, 1'b0);
        single("rsvd", 'h08, 3, 1'b1, 11, 32'h8081_F2F3, 1'b0);
`endif

        // Backpressure: ids 1,2,3 with the consumer stalled
        emitted.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_req('h10, 2, 1'b0, 1);
        step();
        set_req('h14, 2, 1'b0, 2);
        step();
        check_eq("bp_in_ready_low", 32'(in_ready), 32'd0);
        set_req('h18, 2, 1'b0, 3);
        step();
        step();
        check_eq("bp_hold_id", 32'(out_id), 32'd1);
        check_eq("bp_hold_data", out_data, 32'h1000_0004);
        out_ready = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        step();
        step();
        check_eq("bp_count", 32'(emitted.size()), 32'd3);
        for (int i = 0; i < emitted.size() && i < 3; i++)
            check_eq("bp_order", 32'(emitted[i]), 32'(i + 1));

        // Streaming: 8 consecutive transfers at full rate
        emitted.delete();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_req(4 * i, 2, 1'b0, i);
            step();
            check_eq("stream_in_ready", 32'(in_ready), 32'd1);
            if (i > 0) check_eq("stream_emit", 32'(emitted.size()), 32'(i));
        end
        in_valid = 1'b0;
        step();
        check_eq("stream_total", 32'(emitted.size()), 32'd8);

        // Reset while full: buffered entries must never appear
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_req('h20, 2, 1'b0, 12);
        step();
        set_req('h24, 2, 1'b0, 13);
        step();
        check_eq("full_before_rst", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        rst      = 1'b1;
        step();
        rst = 1'b0;
        check_eq("rst_full_valid", 32'(out_valid), 32'd0);
        check_eq("rst_full_ready", 32'(in_ready), 32'd1);
        check_eq("rst_full_data", out_data, 32'd0);
        emitted.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check_eq("rst_no_emit", 32'(emitted.size()), 32'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < NW; i++) in_block[32*i +: 32] = $urandom();
            set_req(int'($urandom_range(0, BW / 8 - 1)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            rst       = ($urandom_range(0, 99) == 0);
            step();
        end
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n0 = 0;
        while (q.size() > 0 && n0 < 4) begin
            step();
            n0++;
        end
        check_eq("drain_empty", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dcache_load_extract.md
Name: dcache_load_extract

Overview:
- Load-return stage between the DCache data array and writeback.
- Takes a full cache block, selects the addressed 32-bit word, then extracts a byte, halfword or word with sign or zero extension.
- Results are registered behind a valid/ready handshake with a 2-entry skid buffer, so a writeback stall never drops a cache hit.
- Generalises the fixed 16-word block mux: block size is parametrised, and the block adds access-size modes, an ID tag and flow control.

Parameters:
- Offset_len, 6, block offset bits; block width = 8 << Offset_len bits; must be at least 2.
- ID_len, 4, width of the load tag carried alongside the data.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  stage can accept a request.
- in_block  input  8<<Offset_len  cache block read data.
- in_offset  input  Offset_len  byte offset within the block.
- in_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
- in_unsigned  input  1  1 = zero-extend, 0 = sign-extend.
- in_id  input  ID_len  load tag.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- out_data  output  32  extended load data.
- out_id  output  ID_len  tag of out_data.
- out_err  output  1  misaligned access or reserved size (only when the feature macro is defined).

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. All state is reset on a rising clk with rst=1.
- Reset values: out_valid=0, out_data=0, out_id=0, out_err=0, in_ready=1, both buffer entries empty.
- Word select: word index = in_offset[Offset_len-1:2]; word = in_block[32*idx +: 32]. Every index is in range by construction.
- Byte select uses in_offset[1:0]. Halfword select uses in_offset[1] only. Little-endian.
- Extension:
  - byte: bit 7 replicated (signed) or zeros.
  - half: bit 15 replicated or zeros.
  - word: passes through unchanged; in_unsigned is ignored.
- Reserved size 11: treated as word.
- The extraction is combinational. The result is written into the buffer on a transfer (in_valid & in_ready).
- Buffer: 2 entries, head (H) and skid (S), held as a FIFO-ordered pair. out_* always show H.
  - States: EMPTY, ONE (H valid), FULL (H and S valid).
  - in_ready = !FULL. It is a registered flag, not a function of out_ready.
  - EMPTY: an input transfer moves to ONE; the result is visible on out_* the next cycle (latency 1).
  - ONE, input only: FULL. Output only: EMPTY. Both at once: stays ONE, H replaced by the new result.
  - FULL: an output transfer moves S to H, state ONE. No input is accepted while FULL.
- Ordering: strictly FIFO; out_id order equals in_id order.
- Throughput: 1 result per cycle while out_ready stays high.
- Output holding: while out_valid=1 and out_ready=0, out_data, out_id and out_err hold stable.
- rst asserted mid-operation: both entries are discarded, outputs return to reset values next cycle, and nothing in flight is emitted.
- When out_valid=0, out_data holds its last value. Consumers must qualify on out_valid.

Optional Feature:
- Macro: DCACHE_LDX_MISALIGN_TRAP_EN.
- Defined:
  - out_err=1 for half with in_offset[0]=1, word with in_offset[1:0]!=0, or size 11.
  - out_data=0 for these requests.
  - The entry still occupies a buffer slot and completes in order.
- Undefined:
  - out_err is tied to 0.
  - Unaligned low offset bits are ignored: half uses in_offset[1]; word uses the aligned word.

Decomposition:
- Shared package dcache_pkg holds:
  - Size encodings LS_BYTE=2'b00, LS_HALF=2'b01, LS_WORD=2'b10.
  - Function/constant for block width (8<<Offset_len) and word count (1<<(Offset_len-2)).
- One sub-module, load_extend: purely combinational word/byte/half select, extension and error detect.
- The top level holds the skid buffer and handshake state.

Test Plan:
- Offset_len=6; block words w[i]=32'h1000_0000+i; word load at offset 0x3C, out_ready=1 -> out_data=32'h1000_000F one cycle after the transfer, out_id matches.
- w[2]=32'h8081_F2F3; signed byte at offset 0x09 -> 32'hFFFF_FFF2; unsigned byte -> 32'h0000_00F2; signed half at offset 0x0A -> 32'hFFFF_8081.
- Back-to-back ids 1,2,3 with out_ready=0 -> in_ready drops after 2 accepts. Then out_ready=1 -> ids 1,2 emerge in order, id 3 accepted next, then emitted; none lost.
- Continuous in_valid and out_ready for 8 cycles -> 8 results on consecutive cycles; in_ready stays 1.
- rst pulsed while FULL -> next cycle out_valid=0, in_ready=1, out_data=0; the previous entries never appear.
- With DCACHE_LDX_MISALIGN_TRAP_EN: word load at offset 0x05 -> out_err=1, out_data=0. Without the macro: the same request -> out_err=0 and out_data is w[1].
